aes_req_arbiter: RTL and testbench

Shares one AES-128 encryption core (`controladorCriptografia`: `chave`, `palavra`, `start` in; `cifra`, `done` out) between two requesters. Typical requesters are the I2C slave register bank and a local test/loopback port. The block arbitrates round-robin and latches the winning key/plaintext. It sequences the core with a reset pulse, then a start pulse, waits for `done` under a timeout, and returns the ciphertext to the winner over a valid/ready response handshake.

---
 rtl/aes_arb_pkg.sv | 15 +
 rtl/rr_grant2.sv | 25 ++
 rtl/aes_req_arbiter.sv | 122 ++++++++++++
 tb/tb_aes_req_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and sizes for the two-requester AES core arbiter.
package aes_arb_pkg;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned AES_W = 128;

  typedef enum logic [2:0] {
    StIdle,
    StCoreRst,
    StStart,
    StWait,
    StResp
  } arb_state_e;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: one-hot grant plus the pointer to use after it.
module rr_grant2
  import aes_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_valid,
  input  logic            prio,
  output logic [NREQ-1:0] gnt,
  output logic            prio_next
);

  always_comb begin
    gnt = req_valid;
    if (&req_valid) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
    // Next pointer favours whoever lost this round.
    prio_next = prio;
    if (gnt[0]) begin
      prio_next = 1'b1;
    end else if (gnt[1]) begin
      prio_next = 1'b0;
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES-128 core between two requesters: round-robin accept, core
// reset/start sequencing, done-or-timeout wait and a valid/ready response.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*AES_W-1:0]  req_chave,
  input  logic [NREQ*AES_W-1:0]  req_palavra,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [AES_W-1:0]       resp_cifra,
  output logic                   resp_erro,
  output logic                   core_rst,
  output logic                   core_start,
  output logic [AES_W-1:0]       core_chave,
  output logic [AES_W-1:0]       core_palavra,
  input  logic                   core_done,
  input  logic [AES_W-1:0]       core_cifra,
  output logic                   busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CICLOS - 1);

  arb_state_e       state_q, state_d;
  logic             prio_q;
  logic             dono_q;
  logic [CntW-1:0]  cnt_q;
  logic [AES_W-1:0] chave_q, palavra_q, cifra_q;
  logic             erro_q;
  logic [NREQ-1:0]  resp_valid_q;
  logic             core_rst_q, core_start_q, busy_q;

  logic [NREQ-1:0]  gnt;
  logic             prio_next;
  logic             accept;

  rr_grant2 u_grant (
    .req_valid (req_valid),
    .prio      (prio_q),
    .gnt       (gnt),
    .prio_next (prio_next)
  );

  // The grant is already masked by req_valid, so any grant bit in IDLE is an accept.
  assign req_ready = (state_q == StIdle && !rst) ? gnt : '0;
  assign accept    = (state_q == StIdle) && (|gnt);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StCoreRst;
      StCoreRst: state_d = StStart;
      StStart:   state_d = StWait;
      StWait:    if (core_done || cnt_q == CntLast) state_d = StResp;
      StResp:    if (resp_ready[dono_q]) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      dono_q       <= 1'b0;
      cnt_q        <= '0;
      chave_q      <= '0;
      palavra_q    <= '0;
      cifra_q      <= '0;
      erro_q       <= 1'b0;
      resp_valid_q <= '0;
      core_rst_q   <= 1'b1;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_rst_q   <= (state_d == StCoreRst);
      core_start_q <= (state_d == StStart);
      busy_q       <= (state_d != StIdle);
      resp_valid_q <= (state_d == StResp) ? (dono_q ? 2'b10 : 2'b01) : 2'b00;

      if (accept) begin
        dono_q    <= gnt[1];
        prio_q    <= prio_next;
        chave_q   <= gnt[1] ? req_chave[2*AES_W-1:AES_W] : req_chave[AES_W-1:0];
        palavra_q <= gnt[1] ? req_palavra[2*AES_W-1:AES_W] : req_palavra[AES_W-1:0];
      end

      if (state_q == StStart) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      // Done wins over a timeout landing in the same cycle.
      if (state_q == StWait) begin
        if (core_done) begin
          cifra_q <= core_cifra;
          erro_q  <= 1'b0;
        end else if (cnt_q == CntLast) begin
          cifra_q <= '0;
          erro_q  <= 1'b1;
        end
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_cifra   = cifra_q;
  assign resp_erro    = erro_q;
  assign core_rst     = core_rst_q;
  assign core_start   = core_start_q;
  assign core_chave   = chave_q;
  assign core_palavra = palavra_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a behavioural AES core stand-in
// that answers the known test vectors after a fixed latency.
module tb_aes_req_arbiter;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_SEQ  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_SEQ  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P_ONES = {128{1'b1}};
  localparam logic [127:0] C_ONES = 128'h3f5b8cc9ea855a0afa7347d23e8d664e;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [255:0] req_chave, req_palavra;
  logic [127:0] resp_cifra, core_chave, core_palavra, core_cifra;
  logic         resp_erro, core_rst, core_start, core_done, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  aes_req_arbiter #(.TIMEOUT_CICLOS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_chave    (req_chave),
    .req_palavra  (req_palavra),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_cifra   (resp_cifra),
    .resp_erro    (resp_erro),
    .core_rst     (core_rst),
    .core_start   (core_start),
    .core_chave   (core_chave),
    .core_palavra (core_palavra),
    .core_done    (core_done),
    .core_cifra   (core_cifra),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Core stand-in: unknown key/plaintext pairs yield a poison value.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    if (k == K_FIPS && p == P_FIPS) return C_FIPS;
    if (k == K_SEQ && p == P_SEQ) return C_SEQ;
    if (k == '0 && p == '0) return C_ZERO;
    if (k == '0 && p == P_ONES) return C_ONES;
    return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  endfunction

  logic core_hang = 1'b0;
  logic run;
  int   ccnt;

  always @(posedge clk) begin
    if (core_rst) begin
      core_done  <= 1'b0;
      core_cifra <= '0;
      run        <= 1'b0;
      ccnt       <= 0;
    end else if (core_start) begin
      run  <= 1'b1;
      ccnt <= 0;
    end else if (run && !core_hang) begin
      if (ccnt == 7) begin
        core_done  <= 1'b1;
        core_cifra <= aes_ref(core_chave, core_palavra);
        run        <= 1'b0;
      end else begin
        ccnt <= ccnt + 1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Serves one pending request: grant, core sequencing, done->resp latency,
  // optional backpressure with the non-owner's ready raised, then handshake.
  task automatic serve(input int idx, input logic [127:0] exp_c, input bit drop,
                       input bit exp_now, input int hold, input string tag);
    logic [1:0] oh;
    int n;
    oh = 2'b01 << idx;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      step();
      n++;
    end
    n_cmp++;
    if (req_ready !== oh || (exp_now && n != 0)) begin
      n_fail++;
      $display("FAIL %s grant: req_ready=%b after %0d cycles, required %b", tag, req_ready, n, oh);
    end
    step();
    if (drop) begin
      req_valid[idx] = 1'b0;
      req_chave[128*idx +: 128]   = {4{$urandom}};
      req_palavra[128*idx +: 128] = {4{$urandom}};
    end
    n_cmp++;
    if ({core_rst, core_start} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s T+1: core_rst/start=%b required 10", tag, {core_rst, core_start});
    end
    step();
    n_cmp++;
    if ({core_rst, core_start} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s T+2: core_rst/start=%b required 01", tag, {core_rst, core_start});
    end
    n = 0;
    while (!core_done && n < 100) begin
      step();
      n++;
    end
    n_cmp++;
    if (core_done !== 1'b1 || resp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL %s done: core_done=%b resp_valid=%b required 1 00", tag, core_done,
               resp_valid);
    end
    step();
    n_cmp++;
    if (resp_valid !== oh || resp_cifra !== exp_c || resp_erro !== 1'b0) begin
      n_fail++;
      $display("FAIL %s resp: valid=%b cifra=%h erro=%b required %b %h 0", tag, resp_valid,
               resp_cifra, resp_erro, oh, exp_c);
    end
    for (int i = 0; i < hold; i++) begin
      resp_ready = ~oh;
      step();
      n_cmp++;
      if (resp_valid !== oh || resp_cifra !== exp_c || req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s hold %0d: valid=%b cifra=%h req_ready=%b busy=%b required %b %h 00 1",
                 tag, i, resp_valid, resp_cifra, req_ready, busy, oh, exp_c);
      end
    end
    resp_ready = oh;
    step();
    resp_ready = 2'b00;
    n_cmp++;
    if (resp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL %s release: resp_valid=%b required 00", tag, resp_valid);
    end
  endtask

  task automatic set_req(input int idx, input logic [127:0] k, input logic [127:0] p);
    req_chave[128*idx +: 128]   = k;
    req_palavra[128*idx +: 128] = p;
    req_valid[idx] = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_cifra !== '0 || resp_erro !== 1'b0 ||
        core_start !== 1'b0 || core_rst !== 1'b1 || core_chave !== '0 || core_palavra !== '0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b rv=%b cif=%h err=%b st=%b crst=%b ch=%h pa=%h busy=%b", tag,
               req_ready, resp_valid, resp_cifra, resp_erro, core_start, core_rst, core_chave,
               core_palavra, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    resp_ready = 2'b00;
    req_chave = '0;
    req_palavra = '0;
    step();
    step();
    check_reset_outputs("reset");
    req_valid = 2'b00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_req(0, K_FIPS, P_FIPS);
    serve(0, C_FIPS, 1'b1, 1'b0, 0, "single");
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    set_req(0, K_SEQ, P_SEQ);
    set_req(1, '0, '0);
    serve(0, C_SEQ, 1'b1, 1'b0, 0, "simul_r0");
    serve(1, C_ZERO, 1'b1, 1'b1, 0, "simul_r1");
  endtask

  task automatic test_fairness();
    set_req(0, K_FIPS, P_FIPS);
    set_req(1, '0, '0);
    serve(0, C_FIPS, 1'b0, 1'b0, 0, "fair0");
    serve(1, C_ZERO, 1'b0, 1'b1, 0, "fair1");
    serve(0, C_FIPS, 1'b0, 1'b1, 0, "fair2");
    serve(1, C_ZERO, 1'b0, 1'b1, 0, "fair3");
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    set_req(1, '0, P_ONES);
    serve(1, C_ONES, 1'b1, 1'b0, 20, "backpr");
  endtask

  task automatic test_timeout();
    int n;
    core_hang = 1'b1;
    set_req(0, K_FIPS, P_FIPS);
    #1;
    n = 0;
    while (req_ready != 2'b01 && n < 20) begin
      step();
      n++;
    end
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 1) req_valid = 2'b00;
      if (k == 18) begin
        n_cmp++;
        if (resp_valid !== 2'b00) begin
          n_fail++;
          $display("FAIL timeout early: resp_valid=%b at T+18 required 00", resp_valid);
        end
      end
    end
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_erro !== 1'b1 || resp_cifra !== '0) begin
      n_fail++;
      $display("FAIL timeout T+19: valid=%b erro=%b cifra=%h required 01 1 0", resp_valid,
               resp_erro, resp_cifra);
    end
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    core_hang = 1'b0;
    set_req(0, K_SEQ, P_SEQ);
    serve(0, C_SEQ, 1'b1, 1'b0, 0, "after_to");
  endtask

  task automatic test_reset_wait();
    int seen;
    set_req(0, K_FIPS, P_FIPS);
    #1;
    for (int n = 0; n < 20 && req_ready != 2'b01; n++) step();
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    step();
    req_valid = 2'b00;
    step();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (resp_valid !== 2'b00 || busy !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_wait abort: %0d cycles with response/busy, required 0", seen);
    end
    set_req(0, '0, P_ONES);
    serve(0, C_ONES, 1'b1, 1'b0, 0, "rst_new");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
